multicycle_ctrl_fsm: RTL

Multi-cycle sequencing controller for the sequential RV64 core. Fetches, decodes and sequences each instruction over several clock cycles, handshaking with instruction and data memory that may stall. Drives per-cycle datapath strobes in place of single-cycle decode outputs. Sits between the memory interfaces and the register file, ALU, immediate generator and PC datapath. Adds an illegal-opcode halt, a memory-timeout fault and a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/insn_decode.sv | 67 ++++++
 rtl/multicycle_ctrl_fsm.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 sequencing controller:
// opcodes, immediate formats, fault codes, FSM states and instruction classes.
package ctrl_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // funct7 that turns the base ALU add into a subtract
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R  = 3'd0,
        CLS_I  = 3'd1,
        CLS_LD = 3'd2,
        CLS_ST = 3'd3,
        CLS_B  = 3'd4
    } insn_class_e;

endpackage

// File: rtl/insn_decode.sv
// Combinational decode of latched opcode/funct fields into class, ALU controls,
// immediate format and a legal flag. CTRL_EXT_BRANCH_EN enables all branch conditions.
module insn_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] insn_class,
    output logic       legal,
    output logic       take_branch,
    output logic [2:0] alu_funct3,
    output logic [6:0] alu_funct7,
    output logic       alu_src_b_sel,
    output logic       is_immediate,
    output logic [2:0] imm_type
);

    always_comb begin
        insn_class    = CLS_R;
        legal         = 1'b1;
        take_branch   = 1'b0;
        alu_funct3    = 3'b000;
        alu_funct7    = 7'b0000000;
        alu_src_b_sel = 1'b0;
        is_immediate  = 1'b0;
        imm_type      = IMM_I;
        case (opcode)
            OP_R: begin
                alu_funct3 = funct3;
                alu_funct7 = funct7;
            end
            OP_I: begin
                insn_class    = CLS_I;
                alu_funct3    = funct3;
                alu_src_b_sel = 1'b1;
                is_immediate  = 1'b1;
            end
            OP_LD: begin
                insn_class    = CLS_LD;
                alu_src_b_sel = 1'b1;
                is_immediate  = 1'b1;
            end
            OP_ST: begin
                insn_class    = CLS_ST;
                alu_src_b_sel = 1'b1;
                is_immediate  = 1'b1;
                imm_type      = IMM_S;
            end
            OP_B: begin
                insn_class = CLS_B;
                alu_funct7 = F7_SUB;
                imm_type   = IMM_B;
`ifdef CTRL_EXT_BRANCH_EN
                alu_funct3  = funct3;
                legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
                take_branch = 1'b1;
`else
                // only beq redirects; other conditions fall through to PC+4
                take_branch = (funct3 == 3'b000);
`endif
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer with illegal-opcode halt, memory timeout
// fault and retired-instruction counter. Branch set selected by CTRL_EXT_BRANCH_EN.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [31:0]      instr,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             branch,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    output logic             alu_src_b_sel,
    output logic             is_immediate,
    output logic [2:0]       imm_type,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]        fault_reg, fault_next;
    logic [CNT_W-1:0]  instret_reg;
    logic [6:0]        opcode_reg, funct7_reg;
    logic [2:0]        funct3_reg;

    logic [2:0] dec_class, dec_funct3, dec_imm_type;
    logic [6:0] dec_funct7;
    logic       dec_legal, dec_take, dec_src_b, dec_is_imm;
    logic       timed_out;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    insn_decode u_decode (
        .opcode       (opcode_reg),
        .funct3       (funct3_reg),
        .funct7       (funct7_reg),
        .insn_class   (dec_class),
        .legal        (dec_legal),
        .take_branch  (dec_take),
        .alu_funct3   (dec_funct3),
        .alu_funct7   (dec_funct7),
        .alu_src_b_sel(dec_src_b),
        .is_immediate (dec_is_imm),
        .imm_type     (dec_imm_type)
    );

    // Ready in the expiry cycle still wins because ready is tested first below.
    assign timed_out = (TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        fault_next    = fault_reg;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        alu_funct3    = 3'b000;
        alu_funct7    = 7'b0000000;
        alu_src_b_sel = 1'b0;
        is_immediate  = 1'b0;
        imm_type      = IMM_I;
        if (state_reg == ST_EXEC || state_reg == ST_MEM) begin
            alu_funct3    = dec_funct3;
            alu_funct7    = dec_funct7;
            alu_src_b_sel = dec_src_b;
            is_immediate  = dec_is_imm;
            imm_type      = dec_imm_type;
        end
        case (state_reg)
            ST_IDLE: begin
                if (run) begin
                    state_next    = ST_FETCH;
                    wait_cnt_next = '0;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (timed_out) begin
                    state_next = ST_HALT;
                    fault_next = FAULT_TIMEOUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_HALT;
                    fault_next = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (dec_class == CLS_B) begin
                    branch   = dec_take;
                    pc_write = 1'b1;
                end else if (dec_class == CLS_LD || dec_class == CLS_ST) begin
                    state_next    = ST_MEM;
                    wait_cnt_next = '0;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_read  = (dec_class == CLS_LD);
                mem_write = (dec_class == CLS_ST);
                if (dmem_ready) begin
                    if (dec_class == CLS_ST) pc_write = 1'b1;
                    else                     state_next = ST_WB;
                end else if (timed_out) begin
                    state_next = ST_HALT;
                    fault_next = FAULT_TIMEOUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            ST_HALT: ;
            default: state_next = ST_IDLE;
        endcase
        // every retiring cycle decides between the next fetch and idling
        if (pc_write) begin
            state_next    = run ? ST_FETCH : ST_IDLE;
            wait_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            fault_reg    <= FAULT_NONE;
            instret_reg  <= '0;
            opcode_reg   <= '0;
            funct3_reg   <= '0;
            funct7_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            fault_reg    <= fault_next;
            if (pc_write) instret_reg <= instret_reg + 1'b1;
            if (ir_write) begin
                opcode_reg <= instr[6:0];
                funct3_reg <= instr[14:12];
                funct7_reg <= instr[31:25];
            end
        end
    end

    assign state   = state_reg;
    assign halted  = (state_reg == ST_HALT);
    assign fault   = fault_reg;
    assign instret = instret_reg;

endmodule
